alu_shift_right_seq: RTL
========================

Name: alu_shift_right_seq

Overview:
- Multi-cycle right shifter for the pipelined CPU execute stage. It is the right-shift counterpart of the combinational left barrel shifter and handles SRL and SRA.
- It applies one power-of-two shift stage per clock: shift by 1, 2, 4, 8, 16, each gated by one shift-amount bit.
- The result is a fixed 5-stage pass, so there are no wide mux levels.
- Valid/ready handshake on both sides, so the hazard unit can stall on it like any multi-cycle ALU op.

Parameters:
- WIDTH, 32, data width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH). This is also the number of BUSY cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort (pipeline flush)
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- dataA  input  WIDTH  value to shift
- dataB  input  SHW  shift amount
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- out_valid  output  1  dataOut holds a result
- out_ready  input  1  consumer takes result
- dataOut  output  WIDTH  shifted result

Behaviour:
- States: IDLE, BUSY, DONE. Registers:
  - acc[WIDTH-1:0]
  - sh[SHW-1:0]
  - ar
  - cnt[2:0]
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, sh=0, ar=0, cnt=0.
  - out_valid=0, dataOut=0, in_ready=1.
- in_ready = (state==IDLE). out_valid = (state==DONE). dataOut = acc, always driven.
- IDLE: on in_valid && in_ready at a clock edge:
  - acc<=dataA, sh<=dataB, ar<=arith, cnt<=0.
  - state<=BUSY.
- BUSY, each cycle:
  - If sh[cnt]=1: acc <= acc >> (2**cnt), vacated MSBs filled with (ar ? acc[WIDTH-1] : 0). Else acc is unchanged.
  - cnt<=cnt+1.
  - When cnt==SHW-1 the stage is applied and state<=DONE.
- Sign handling: stages are applied in order 1,2,4,8,16. The fill bit is always the current acc MSB, which equals the original sign for SRA.
- DONE:
  - acc is held stable while out_ready=0.
  - On out_ready=1, state<=IDLE at the edge.
  - There is no same-cycle re-accept: in_ready stays 0 in DONE.
- Latency:
  - Operands are accepted at edge E0.
  - out_valid rises after edge E(SHW), i.e. E5 for 32-bit.
  - Minimum issue interval is SHW+2 cycles (accept edge, 5 BUSY edges, 1 DONE edge).
- dataB=0: passes through all 5 BUSY cycles unchanged. Result equals dataA.
- dataB=31: result is all-fill (SRA: 0xFFFFFFFF if negative else 0; SRL: dataA[31] in bit 0).
- flush=1 at an edge in any state:
  - state<=IDLE, cnt<=0. acc keeps its value.
  - out_valid drops next cycle.
  - flush has priority over acceptance and over the out_ready handshake.
- Reset mid-BUSY or mid-DONE: immediate return to reset values. No partial result is ever presented.
- in_valid while not IDLE is ignored. The producer must hold its operands until in_ready.

Optional Feature:
- Macro: SHIFTER_ZERO_SKIP_EN.
- Defined:
  - At acceptance, if dataB==0, state goes IDLE->DONE directly with acc<=dataA. out_valid rises after E1.
  - In BUSY, if all remaining bits sh[SHW-1:cnt] are 0, the block goes to DONE on that edge without applying further (no-op) stages. Latency becomes 1 + index of highest set bit of dataB.
- Undefined: latency is fixed at SHW cycles for every operand, as described above.
- The result value is identical either way.

Test Plan:
- SRA/SRL of negative value: dataA=0x80000000, dataB=4.
  - arith=1 -> dataOut=0xF8000000.
  - arith=0 -> dataOut=0x08000000.
  - out_valid asserted exactly 5 cycles after accept (macro off).
- Maximum shift: dataA=0xDEADBEEF, dataB=31.
  - arith=0 -> 0x00000001.
  - arith=1 -> 0xFFFFFFFF.
  - dataA=0x7FFFFFFF, dataB=31, arith=1 -> 0x00000000.
- Backpressure: result 0x12345678 >>0, with out_ready held low 3 cycles.
  - dataOut and out_valid stay stable.
  - in_ready stays 0.
  - Raising out_ready -> IDLE and in_ready=1 next cycle.
  - A second op issued immediately yields the correct result.
- Flush and reset:
  - flush pulsed in 3rd BUSY cycle -> out_valid never rises, in_ready=1 next cycle.
  - rst_n pulsed low mid-BUSY -> all outputs at reset values asynchronously, no stale DONE after release.
- Exhaustive sweep: random dataA, all dataB 0..31, both arith values. Compare against reference >> / >>> model, 10k ops with random out_ready.
- SHIFTER_ZERO_SKIP_EN defined:
  - dataB=0 -> out_valid after 1 cycle.
  - dataB=3 -> 2 cycles.
  - dataB=16 -> 5 cycles.
  - Results identical to macro-off run.

Source files
------------

// File: rtl/alu_shift_right_seq.sv
// Multi-cycle SRL/SRA unit: one power-of-two shift stage per clock, valid/ready on both sides.
// Optional SHIFTER_ZERO_SKIP_EN: finish early once no set shift-amount bits remain.
module alu_shift_right_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dataA,
   input  logic [SHW-1:0]   dataB,
   input  logic             arith,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dataOut
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAST_CNT = 3'(SHW - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [SHW-1:0]   sh_reg, sh_next;
   logic             ar_reg, ar_next;
   logic [2:0]       cnt_reg, cnt_next;

   logic             accept;
   logic             fill;
   logic [WIDTH-1:0] stage_out [SHW];
   logic [SHW-1:0]   upper_zero;

   assign accept = in_valid && (state_reg == IDLE);

   // Fill is the live MSB; for SRA it still equals the original sign at every stage.
   assign fill = ar_reg & acc_reg[WIDTH-1];

   genvar gi;
   generate
      for (gi = 0; gi < SHW; gi++) begin : g_stage
         localparam int AMT = 1 << gi;
         assign stage_out[gi] = {{AMT{fill}}, acc_reg[WIDTH-1:AMT]};

         // upper_zero[gi]: no shift-amount bits set above stage gi
         if (gi == SHW - 1) begin : g_top
            assign upper_zero[gi] = 1'b1;
         end else begin : g_rest
            assign upper_zero[gi] = ~|sh_reg[SHW-1:gi+1];
         end
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         sh_reg    <= '0;
         ar_reg    <= 1'b0;
         cnt_reg   <= 3'd0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         sh_reg    <= sh_next;
         ar_reg    <= ar_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic; flush overrides everything
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
`ifdef SHIFTER_ZERO_SKIP_EN
                  state_next = (dataB == '0) ? DONE : BUSY;
`else
                  state_next = BUSY;
`endif
               end
            end
            BUSY: begin
               if (cnt_reg == LAST_CNT) begin
                  state_next = DONE;
               end
`ifdef SHIFTER_ZERO_SKIP_EN
               else if (upper_zero[cnt_reg]) begin
                  state_next = DONE;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath next values; flush leaves acc untouched
   always_comb begin
      acc_next = acc_reg;
      sh_next  = sh_reg;
      ar_next  = ar_reg;
      cnt_next = cnt_reg;
      if (flush) begin
         cnt_next = 3'd0;
      end else if (accept) begin
         acc_next = dataA;
         sh_next  = dataB;
         ar_next  = arith;
         cnt_next = 3'd0;
      end else if (state_reg == BUSY) begin
         if (sh_reg[cnt_reg]) begin
            acc_next = stage_out[cnt_reg];
         end
         cnt_next = cnt_reg + 3'd1;
      end
   end

   // Outputs depend on state only, so no partial result is ever visible
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
      dataOut   = acc_reg;
   end

   // Unused when the early-exit path is compiled out
   logic unused_ok;
   assign unused_ok = &{1'b0, upper_zero};

endmodule
